// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: stall/flush
// generation, E-stage forwarding selects and the data-memory request FSM.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       D_rs1,
    input  logic [4:0]       D_rs2,
    input  logic             D_use_rs1,
    input  logic             D_use_rs2,
    input  logic [4:0]       E_op,
    input  logic [4:0]       M_op,
    input  logic [4:0]       W_op,
    input  logic [4:0]       E_rd,
    input  logic [4:0]       M_rd,
    input  logic [4:0]       W_rd,
    input  logic [4:0]       E_rs1,
    input  logic [4:0]       E_rs2,
    input  logic             E_redirect,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [7:0] TIMEOUT   = 8'(MEM_TIMEOUT);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           r_state;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_mem_op;
    logic w_mem_req;
    logic w_mem_stall;
    logic w_abort;
    logic w_lu;

    function automatic logic writes_rd(input logic [4:0] op, input logic [4:0] rd);
        return (op != OP_STORE) && (op != OP_BRANCH) && (rd != 5'd0);
    endfunction

    // Loads are excluded from the M path: their data only exists once in W.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] m_op, input logic [4:0] m_rd,
                                           input logic [4:0] w_op, input logic [4:0] w_rd);
        if (writes_rd(m_op, m_rd) && (m_op != OP_LOAD) && (m_rd == src))
            return 2'b01;
        else if (writes_rd(w_op, w_rd) && (w_rd == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign w_mem_op = (M_op == OP_LOAD) || (M_op == OP_STORE);
    assign w_lu     = (E_op == OP_LOAD) && (E_rd != 5'd0) &&
                      ((D_use_rs1 && (D_rs1 == E_rd)) || (D_use_rs2 && (D_rs2 == E_rd)));

    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_stall = 1'b0;
        w_abort     = 1'b0;
        if (!rst) begin
            unique case (r_state)
                S_IDLE: begin
                    w_mem_req   = w_mem_op;
                    w_mem_stall = w_mem_op && !dmem_ack;
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        w_mem_req = 1'b1;
                    end else if (r_wait_cnt < TIMEOUT) begin
                        w_mem_req   = 1'b1;
                        w_mem_stall = 1'b1;
                    end else begin
                        w_abort = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A memory stall freezes E, so a pending redirect simply waits for it.
    always_comb begin
        stall_F     = 1'b0;
        stall_D     = 1'b0;
        stall_E     = 1'b0;
        stall_M     = 1'b0;
        flush_D     = 1'b0;
        flush_E     = 1'b0;
        flush_W     = 1'b0;
        fwd_rs1_sel = 2'b00;
        fwd_rs2_sel = 2'b00;
        if (!rst) begin
            fwd_rs1_sel = fwd_sel(E_rs1, M_op, M_rd, W_op, W_rd);
            fwd_rs2_sel = fwd_sel(E_rs2, M_op, M_rd, W_op, W_rd);
            if (w_mem_stall) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                flush_W = 1'b1;
            end else if (E_redirect) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (w_lu) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 8'd0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_mem_op && !dmem_ack) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        r_state <= S_IDLE;
                    end else if (w_abort) begin
                        r_state   <= S_IDLE;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (stall_F && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign dmem_req  = w_mem_req;
    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;

endmodule
